// File: rtl/phase_div_pkg.sv
// phase_div_pkg: shared constants, phase encodings and quarter-bound helper
// for the phase_divider block.
package phase_div_pkg;

  localparam int MIN_DIV_DEF = 4;
  localparam int QB_W        = 32;

  typedef enum logic [1:0] {
    PH_HI0 = 2'd0,
    PH_HI1 = 2'd1,
    PH_LO0 = 2'd2,
    PH_LO1 = 2'd3
  } phase_e;

  typedef struct packed {
    logic [QB_W-1:0] q1;
    logic [QB_W-1:0] q2;
    logic [QB_W-1:0] q3;
  } qbounds_t;

  // q3 <= 3/4 of per, so the sum never overflows the period width.
  function automatic qbounds_t quarter_bounds(
    input logic [QB_W-1:0] per
  );
    qbounds_t b;
    b.q2 = per >> 1;
    b.q1 = b.q2 >> 1;
    b.q3 = b.q1 + b.q2;
    return b;
  endfunction

endpackage

// File: rtl/phase_div_if.sv
// phase_div_if: control/status bundle of phase_divider.
// EN, DIV, DIV_Load (+Stretch_In) in; DIV_Ack, CLK_Out, Phase, Tick out.
interface phase_div_if #(
  parameter int CNT_W = 16
) ();

  logic             EN;
  logic [CNT_W-1:0] DIV;
  logic             DIV_Load;
  logic             DIV_Ack;
  logic             CLK_Out;
  logic [1:0]       Phase;
  logic             Tick;
`ifdef PHASE_DIV_STRETCH_EN
  logic             Stretch_In;
`endif

  modport master (
    output EN, DIV, DIV_Load,
`ifdef PHASE_DIV_STRETCH_EN
    output Stretch_In,
`endif
    input  DIV_Ack, CLK_Out, Phase, Tick
  );

  modport slave (
    input  EN, DIV, DIV_Load,
`ifdef PHASE_DIV_STRETCH_EN
    input  Stretch_In,
`endif
    output DIV_Ack, CLK_Out, Phase, Tick
  );

endinterface

// File: rtl/phase_div_cnt.sv
// phase_div_cnt: 0..per-1 wrap counter with enable and stall-at-value.
// Ports: clk_i, rst_i, en_i, stall_i, stall_at_i, per_i -> cnt_next_o, adv_o, wrap_o.
module phase_div_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             stall_i,
  input  logic [CNT_W-1:0] stall_at_i,
  input  logic [CNT_W-1:0] per_i,
  output logic [CNT_W-1:0] cnt_next_o,
  output logic             adv_o,
  output logic             wrap_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             at_end;

  always_comb begin
    at_end = (cnt_q == per_i - CNT_W'(1));
    // A stall only bites while parked on its target count.
    adv_o  = en_i && !(stall_i && (cnt_q == stall_at_i));
    wrap_o = adv_o && at_end;
    cnt_d  = cnt_q;
    if (adv_o)
      cnt_d = at_end ? '0 : cnt_q + CNT_W'(1);
  end

  assign cnt_next_o = cnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/phase_divider.sv
// phase_divider: programmable ~50% clock divider with quarter-phase strobes.
// Ports: CLK, RST (async, high), bus (phase_div_if.slave). Option macro: PHASE_DIV_STRETCH_EN.
module phase_divider
  import phase_div_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int DEF_DIV = 500,
  parameter int MIN_DIV = MIN_DIV_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  phase_div_if.slave bus
);

  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic [CNT_W-1:0] div_cl;
  logic             pend_v_q, pend_v_d;
  logic             ack_q, ack_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  phase_e           ph_q, ph_d;

  logic [CNT_W-1:0] cnt_next;
  logic             adv, wrap, stall;
  logic [QB_W-1:0]  nx;
  qbounds_t         qb;

`ifdef PHASE_DIV_STRETCH_EN
  assign stall = ~bus.Stretch_In;
`else
  assign stall = 1'b0;
`endif

  // Stall target is q1 of the active period (per>>1>>1).
  phase_div_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk_i      (CLK),
    .rst_i      (RST),
    .en_i       (bus.EN),
    .stall_i    (stall),
    .stall_at_i (per_q >> 2),
    .per_i      (per_q),
    .cnt_next_o (cnt_next),
    .adv_o      (adv),
    .wrap_o     (wrap)
  );

  always_comb begin
    div_cl = (bus.DIV < CNT_W'(MIN_DIV)) ?
             CNT_W'(MIN_DIV) : bus.DIV;
    per_d    = per_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    ack_d    = 1'b0;
    clk_d    = clk_q;
    ph_d     = ph_q;
    tick_d   = 1'b0;

    // Old pending value lands first; a same-edge load re-arms.
    if (wrap && pend_v_q) begin
      per_d    = pend_q;
      pend_v_d = 1'b0;
      ack_d    = 1'b1;
    end
    if (bus.DIV_Load) begin
      pend_d   = div_cl;
      pend_v_d = 1'b1;
    end

    qb = quarter_bounds(QB_W'(per_d));
    nx = QB_W'(cnt_next);

    if (adv) begin
      clk_d = (nx < qb.q2);
      if (nx < qb.q1)      ph_d = PH_HI0;
      else if (nx < qb.q2) ph_d = PH_HI1;
      else if (nx < qb.q3) ph_d = PH_LO0;
      else                 ph_d = PH_LO1;
      tick_d = (nx == '0) || (nx == qb.q1) ||
               (nx == qb.q2) || (nx == qb.q3);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      per_q    <= CNT_W'(DEF_DIV);
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      ack_q    <= 1'b0;
      clk_q    <= 1'b0;
      ph_q     <= PH_HI0;
      tick_q   <= 1'b0;
    end else begin
      per_q    <= per_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      ack_q    <= ack_d;
      clk_q    <= clk_d;
      ph_q     <= ph_d;
      tick_q   <= tick_d;
    end
  end

  assign bus.DIV_Ack = ack_q;
  assign bus.CLK_Out = clk_q;
  assign bus.Phase   = ph_q;
  assign bus.Tick    = tick_q;

endmodule

// File: tb/tb_phase_divider.sv
// tb_phase_divider: directed bench for phase_divider (DEF_DIV=10).
// Optional stretch scenario runs when PHASE_DIV_STRETCH_EN is defined.
module tb_phase_divider;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   errs = 0;
  int   checks = 0;

  int   c_m, per_m, pend_m;
  bit   pv_m, ack_m;

  phase_div_if #(.CNT_W(16)) bus ();

  phase_divider #(.CNT_W(16), .DEF_DIV(10)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  logic [1:0] PH10 [10] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1,
                            2'd2, 2'd2, 2'd3, 2'd3, 2'd3};
  logic [1:0] PH8  [8]  = '{2'd0, 2'd0, 2'd1, 2'd1,
                            2'd2, 2'd2, 2'd3, 2'd3};
  logic [1:0] PH6  [6]  = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3};
  logic [1:0] PH4  [4]  = '{2'd0, 2'd1, 2'd2, 2'd3};
  logic [9:0] TK10 = 10'b0010100101;
  logic [7:0] TK8  = 8'b01010101;
  logic [5:0] TK6  = 6'b011011;
  logic [3:0] TK4  = 4'b1111;

  // {Tick, CLK_Out, Phase} after an enabled edge landing on count c.
  function automatic logic [3:0] expv(int p, int c);
    logic       tk;
    logic [1:0] ph;
    case (p)
      10:      begin tk = TK10[c]; ph = PH10[c]; end
      8:       begin tk = TK8[c];  ph = PH8[c];  end
      6:       begin tk = TK6[c];  ph = PH6[c];  end
      4:       begin tk = TK4[c];  ph = PH4[c];  end
      default: begin tk = 1'bx;    ph = 2'bxx;   end
    endcase
    return {tk, (c < p / 2), ph};
  endfunction

  // One clock with optional load; updates the reference state.
  task automatic step(input bit ld, input int val);
    bus.DIV      = 16'(val);
    bus.DIV_Load = ld;
    @(posedge CLK);
    #1;
    bus.DIV_Load = 1'b0;
    ack_m = 1'b0;
    if (bus.EN) begin
      if (c_m == per_m - 1) begin
        c_m = 0;
        if (pv_m) begin
          per_m = pend_m;
          pv_m  = 1'b0;
          ack_m = 1'b1;
        end
      end else begin
        c_m++;
      end
    end
    if (ld) begin
      pend_m = (val < 4) ? 4 : val;
      pv_m   = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [3:0] got;
    RST = 1'b1;
    bus.EN = 1'b0;
    bus.DIV = '0;
    bus.DIV_Load = 1'b0;
`ifdef PHASE_DIV_STRETCH_EN
    bus.Stretch_In = 1'b1;
`endif
    repeat (2) @(posedge CLK);
    #1;
    got = {bus.Tick, bus.CLK_Out, bus.Phase};
    checks++;
    if (got !== 4'b0000) begin
      errs++;
      $display("FAIL reset_outs got=%b exp=0000", got);
    end
    checks++;
    if (bus.DIV_Ack !== 1'b0) begin
      errs++;
      $display("FAIL reset_ack got=%b exp=0", bus.DIV_Ack);
    end
    RST = 1'b0;
    bus.EN = 1'b1;
    c_m = 0; per_m = 10; pend_m = 0; pv_m = 0; ack_m = 0;
  endtask

  task automatic test_default();
    logic [3:0] got, e;
    int nt, nh;
    nt = 0; nh = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 0);
      got = {bus.Tick, bus.CLK_Out, bus.Phase};
      e = expv(per_m, c_m);
      checks++;
      if (got !== e || bus.DIV_Ack !== ack_m) begin
        errs++;
        $display("FAIL default c=%0d got=%b/%b exp=%b/%b",
                 c_m, got, bus.DIV_Ack, e, ack_m);
      end
      nt += int'(bus.Tick);
      nh += int'(bus.CLK_Out);
    end
    checks++;
    if (nt != 8 || nh != 10) begin
      errs++;
      $display("FAIL default_counts ticks=%0d high=%0d exp=8/10",
               nt, nh);
    end
  endtask

  // Shared shape for load scenarios: n steps, loads at given steps.
  task automatic run_loads(input string nm, input int n,
                           input int i0, input int v0,
                           input int i1, input int v1,
                           input int acks_exp);
    logic [3:0] got, e;
    int na;
    bit ld;
    int v;
    na = 0;
    for (int i = 0; i < n; i++) begin
      ld = (i == i0) || (i == i1);
      v  = (i == i0) ? v0 : v1;
      step(ld, v);
      got = {bus.Tick, bus.CLK_Out, bus.Phase};
      e = expv(per_m, c_m);
      checks++;
      if (got !== e || bus.DIV_Ack !== ack_m) begin
        errs++;
        $display("FAIL %s i=%0d c=%0d got=%b/%b exp=%b/%b",
                 nm, i, c_m, got, bus.DIV_Ack, e, ack_m);
      end
      na += int'(bus.DIV_Ack);
    end
    checks++;
    if (na != acks_exp) begin
      errs++;
      $display("FAIL %s_acks got=%0d exp=%0d", nm, na, acks_exp);
    end
  endtask

  task automatic test_reload();
    run_loads("reload8", 26, 3, 8, -1, 0, 1);
    checks++;
    if (per_m != 8 || c_m != 0) begin
      errs++;
      $display("FAIL reload_state per=%0d c=%0d exp=8/0", per_m, c_m);
    end
  endtask

  task automatic test_clamp();
    run_loads("clamp2", 16, 0, 2, -1, 0, 1);
  endtask

  task automatic test_back_to_back();
    run_loads("double", 16, 0, 12, 1, 6, 1);
  endtask

  task automatic test_wrap_load();
    run_loads("wrapload", 24, 0, 10, 5, 8, 2);
  endtask

  task automatic test_freeze();
    logic [3:0] got, e;
    for (int i = 0; i < 3; i++) step(1'b0, 0);
    e = expv(per_m, c_m);
    bus.EN = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 0);
      got = {bus.Tick, bus.CLK_Out, bus.Phase};
      checks++;
      if (got !== {1'b0, e[2:0]} || bus.DIV_Ack !== 1'b0) begin
        errs++;
        $display("FAIL freeze i=%0d got=%b/%b exp=%b/0",
                 i, got, bus.DIV_Ack, {1'b0, e[2:0]});
      end
    end
    bus.EN = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 0);
      got = {bus.Tick, bus.CLK_Out, bus.Phase};
      e = expv(per_m, c_m);
      checks++;
      if (got !== e || bus.DIV_Ack !== ack_m) begin
        errs++;
        $display("FAIL resume c=%0d got=%b exp=%b", c_m, got, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] got, e;
    int na;
    for (int i = 0; i < 6; i++) step(i == 3, 12);
    #2;
    RST = 1'b1;
    #1;
    got = {bus.Tick, bus.CLK_Out, bus.Phase};
    checks++;
    if (got !== 4'b0000 || bus.DIV_Ack !== 1'b0) begin
      errs++;
      $display("FAIL async_reset got=%b/%b exp=0000/0",
               got, bus.DIV_Ack);
    end
    @(posedge CLK);
    #1;
    RST = 1'b0;
    c_m = 0; per_m = 10; pv_m = 0; ack_m = 0;
    na = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 0);
      got = {bus.Tick, bus.CLK_Out, bus.Phase};
      e = expv(per_m, c_m);
      checks++;
      if (got !== e) begin
        errs++;
        $display("FAIL post_reset c=%0d got=%b exp=%b", c_m, got, e);
      end
      na += int'(bus.DIV_Ack);
    end
    checks++;
    if (na != 0) begin
      errs++;
      $display("FAIL post_reset_acks got=%0d exp=0", na);
    end
  endtask

`ifdef PHASE_DIV_STRETCH_EN
  task automatic test_stretch();
    logic [3:0] got, e;
    int nt;
    step(1'b0, 0);
    bus.Stretch_In = 1'b0;
    step(1'b0, 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK);
      #1;
      got = {bus.Tick, bus.CLK_Out, bus.Phase};
      checks++;
      if (got !== 4'b0101) begin
        errs++;
        $display("FAIL stretch_hold i=%0d got=%b exp=0101", i, got);
      end
    end
    bus.Stretch_In = 1'b1;
    nt = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 0);
      got = {bus.Tick, bus.CLK_Out, bus.Phase};
      e = expv(per_m, c_m);
      checks++;
      if (got !== e) begin
        errs++;
        $display("FAIL stretch_run c=%0d got=%b exp=%b", c_m, got, e);
      end
      nt += int'(bus.Tick);
    end
    checks++;
    if (nt != 3) begin
      errs++;
      $display("FAIL stretch_ticks got=%0d exp=3", nt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_default();
    test_reload();
    test_clamp();
    test_back_to_back();
    test_wrap_load();
    test_freeze();
    test_reset_mid();
`ifdef PHASE_DIV_STRETCH_EN
    test_stretch();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/phase_divider.md
Name: phase_divider

Overview:
Next-generation clock divider for the IIC core: runtime-programmable period instead of a fixed FREQ/CLK_FREQ ratio. Produces a ~50% divided clock plus quarter-phase strobes (start, mid-high, falling, mid-low) used by the IIC bit engine to time SCL/SDA changes and sampling. Sits between the system clock and the IIC master FSM. Divisor changes are glitch-free.

Parameters:
CNT_W, 16, width of period/counter.
DEF_DIV, 500, period in CLK cycles after reset (50 MHz -> 100 kHz).
MIN_DIV, 4, smallest legal period; smaller loads are clamped.

Ports:
CLK  in  1  system clock, rising edge.
RST  in  1  asynchronous reset, active-high.
EN  in  1  count enable; low = freeze.
DIV  in  CNT_W  requested period in CLK cycles.
DIV_Load  in  1  one-cycle strobe; capture DIV as pending period.
DIV_Ack  out  1  one-cycle pulse when the pending period takes effect.
CLK_Out  out  1  divided clock.
Phase  out  2  current quarter: 0 = first high, 1 = second high, 2 = first low, 3 = second low.
Tick  out  1  one-cycle strobe on entry to each quarter.

Behaviour:
- One clock (CLK); reset is asynchronous and active-high (RST).
- Registers:
  - per: active period; reset DEF_DIV.
  - pend, pend_v: pending period and valid flag; reset 0.
  - cnt: counter, 0..per-1; reset 0.
- Quarter bounds from per: q1 = per>>1>>1, q2 = per>>1, q3 = q1+q2. Computed in CNT_W bits, no overflow. Example per=10: q1=2, q2=5, q3=7.
- Reset values: CLK_Out=0, Phase=0, Tick=0, DIV_Ack=0.
- Enabled cycle (EN=1):
  - cnt_next = (cnt==per-1) ? 0 : cnt+1.
  - Outputs are registered from cnt_next, so they are aligned with cnt.
  - CLK_Out = (cnt_next < q2).
  - Phase = 0 if cnt_next < q1; 1 if < q2; 2 if < q3; else 3.
  - Tick = 1 when cnt_next is 0, q1, q2 or q3.
- First enabled edge after reset: cnt 0->1; no Tick at power-up.
- Wrap rule: at cnt==per-1 with pend_v=1:
  - per <= pend, pend_v <= 0, DIV_Ack <= 1.
  - Quarter bounds for cnt_next=0 use the new per.
  - The period in progress always completes with the old value.
- Load rules:
  - DIV_Load sets pend = max(DIV, MIN_DIV) and pend_v = 1.
  - A second load before the wrap overwrites pend; only one DIV_Ack is issued.
  - Load on the same edge as the wrap: the old pending value is applied now; the new one becomes pending.
- EN=0: cnt, per and outputs hold; Tick=0; DIV_Ack=0. Loads are still captured; the wrap is deferred until EN=1.
- RST mid-period: immediate return to reset values; pending load discarded.

Optional Feature:
PHASE_DIV_STRETCH_EN adds input Stretch_In (1 bit, IIC SCL line sense).
- With macro: while cnt==q1 and Stretch_In==0, cnt holds and Tick stays 0. Phase=1 and CLK_Out=1 are held. Counting resumes the cycle after Stretch_In=1, with no repeated Tick.
- Without macro: no port; never holds.

Decomposition:
- Package phase_div_pkg: MIN_DIV default, PH_HI0/PH_HI1/PH_LO0/PH_LO1 encodings (0..3), quarter-bound function.
- Sub-module phase_div_cnt: wrap counter with enable/hold, emitting cnt_next and a wrap flag.
- Top-level phase_divider: period/pending registers and output decode.

Test Plan:
- Reset release, EN=1, DEF_DIV=10 -> Tick at cnt 2,5,7,0 every 10 cycles; CLK_Out high for 5 cycles, low for 5; Phase sequence 0,0,1,1,1,2,2,3,3,3.
- DIV=8 loaded mid-period -> current 10-cycle period completes; DIV_Ack on the wrap edge; next periods 8 cycles with Ticks at 0,2,4,6.
- DIV=2 loaded -> clamped to 4; CLK_Out 2 high / 2 low; a Tick every cycle.
- Two loads (12 then 6) before one wrap -> single DIV_Ack; period becomes 6.
- EN low for 7 cycles mid-period -> outputs frozen, Tick=0; resume continues from the same cnt.
- RST asserted at cnt=6 with a load pending -> outputs 0 asynchronously; after release, period = DEF_DIV and no DIV_Ack. With PHASE_DIV_STRETCH_EN: Stretch_In low 5 cycles at q1 -> period extended by 5 cycles.
